// File: rtl/fc3_bias_argmax.sv
// FC3 output stage: adds the per-batch bias with saturation, then scans every class for the running argmax.
// Latency: ROM, ADD and N_PER compare cycles per batch; the result follows the last batch by N_PER+3 cycles. Accepts one batch only in IDLE; the result holds until taken.
module fc3_bias_argmax #(
    parameter int N_BATCH = 5,
    parameter int N_PER   = 5,
    parameter int W_BIAS  = 34,
    parameter int W_ACC   = 40,
    parameter int W_AA    = 3,
    parameter int W_CLS   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      acc_valid_i,
    output logic                      acc_ready_o,
    input  logic [N_PER*W_ACC-1:0]    acc_data_i,
    output logic [W_AA-1:0]           rom_aa_o,
    output logic                      rom_cena_o,
    input  logic [N_PER*W_BIAS-1:0]   rom_qa_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [W_CLS-1:0]          res_class_o,
    output logic [W_ACC-1:0]          res_score_o
);
    localparam int W_LC = (N_PER > 1) ? $clog2(N_PER) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ROM, S_ADD, S_CMP, S_DONE} state_t;

    state_t                    state_q;
    logic signed [W_ACC-1:0]   lane_q [N_PER];
    logic [W_AA-1:0]           batch_q;
    logic [W_LC-1:0]           lcnt_q;
    logic signed [W_ACC-1:0]   max_q;
    logic [W_CLS-1:0]          max_idx_q;
    logic                      max_vld_q;
    logic                      acc_rdy_q;
    logic                      cena_q;
    logic [W_AA-1:0]           aa_q;
    logic                      res_vld_q;
    logic [W_CLS-1:0]          res_cls_q;
    logic [W_ACC-1:0]          res_score_q;

    logic signed [W_ACC:0]     wide_s [N_PER];
    logic signed [W_ACC-1:0]   sat_d  [N_PER];
    logic signed [W_ACC-1:0]   cur_lane;
    logic                      upd;
    logic [W_CLS-1:0]          idx_d;

    // Sum at W_ACC+1 bits; top two bits differing means the result left the W_ACC range.
    always_comb begin
        for (int k = 0; k < N_PER; k++) begin
            wide_s[k] = {lane_q[k][W_ACC-1], lane_q[k]}
                      + {{(W_ACC+1-W_BIAS){rom_qa_i[(N_PER-k)*W_BIAS-1]}},
                         rom_qa_i[(N_PER-k)*W_BIAS-1 -: W_BIAS]};
            if (wide_s[k][W_ACC] != wide_s[k][W_ACC-1])
                sat_d[k] = wide_s[k][W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}}
                                            : {1'b0, {(W_ACC-1){1'b1}}};
            else
                sat_d[k] = wide_s[k][W_ACC-1:0];
        end
    end

    always_comb begin
        cur_lane = lane_q[lcnt_q];
        upd      = !max_vld_q || (cur_lane > max_q);
        idx_d    = W_CLS'(batch_q) * W_CLS'(N_PER) + W_CLS'(lcnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int k = 0; k < N_PER; k++) lane_q[k] <= '0;
            batch_q     <= '0;
            lcnt_q      <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            max_vld_q   <= 1'b0;
            acc_rdy_q   <= 1'b0;
            cena_q      <= 1'b1;
            aa_q        <= '0;
            res_vld_q   <= 1'b0;
            res_cls_q   <= '0;
            res_score_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    acc_rdy_q <= 1'b1;
                    if (acc_valid_i && acc_rdy_q) begin
                        for (int k = 0; k < N_PER; k++)
                            lane_q[k] <= acc_data_i[(N_PER-k)*W_ACC-1 -: W_ACC];
                        acc_rdy_q <= 1'b0;
                        cena_q    <= 1'b0;
                        aa_q      <= batch_q;
                        state_q   <= S_ROM;
                    end
                end
                S_ROM: begin
                    cena_q  <= 1'b1;
                    state_q <= S_ADD;
                end
                S_ADD: begin
                    for (int k = 0; k < N_PER; k++) lane_q[k] <= sat_d[k];
                    lcnt_q  <= '0;
                    state_q <= S_CMP;
                end
                S_CMP: begin
                    if (upd) begin
                        max_q     <= cur_lane;
                        max_idx_q <= idx_d;
                        max_vld_q <= 1'b1;
                    end
                    lcnt_q <= lcnt_q + W_LC'(1);
                    if (lcnt_q == W_LC'(N_PER-1)) begin
                        if (batch_q == W_AA'(N_BATCH-1)) begin
                            // The final lane's update lands this same edge, so resolve it here.
                            res_vld_q   <= 1'b1;
                            res_cls_q   <= upd ? idx_d : max_idx_q;
                            res_score_q <= upd ? cur_lane : max_q;
                            state_q     <= S_DONE;
                        end else begin
                            batch_q   <= batch_q + W_AA'(1);
                            acc_rdy_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        res_vld_q <= 1'b0;
                        batch_q   <= '0;
                        max_vld_q <= 1'b0;
                        acc_rdy_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign acc_ready_o = acc_rdy_q;
    assign rom_cena_o  = cena_q;
    assign rom_aa_o    = aa_q;
    assign res_valid_o = res_vld_q;
    assign res_class_o = res_cls_q;
    assign res_score_o = res_score_q;
endmodule

// File: tb/tb_fc3_bias_argmax.sv
// Directed bench for fc3_bias_argmax with a behavioural bias ROM and hand-computed argmax results.
module tb_fc3_bias_argmax;
    localparam int N_BATCH = 5;
    localparam int N_PER   = 5;
    localparam int W_BIAS  = 34;
    localparam int W_ACC   = 40;
    localparam int W_AA    = 3;
    localparam int W_CLS   = 5;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     acc_valid = 1'b0;
    logic                     acc_ready;
    logic [N_PER*W_ACC-1:0]   acc_data = '0;
    logic [W_AA-1:0]          rom_aa;
    logic                     rom_cena;
    logic [N_PER*W_BIAS-1:0]  rom_qa = '0;
    logic                     res_valid;
    logic                     res_ready = 1'b0;
    logic [W_CLS-1:0]         res_class;
    logic [W_ACC-1:0]         res_score;

    fc3_bias_argmax #(
        .N_BATCH(N_BATCH), .N_PER(N_PER), .W_BIAS(W_BIAS),
        .W_ACC(W_ACC), .W_AA(W_AA), .W_CLS(W_CLS)
    ) dut (
        .clk(clk), .rst(rst),
        .acc_valid_i(acc_valid), .acc_ready_o(acc_ready), .acc_data_i(acc_data),
        .rom_aa_o(rom_aa), .rom_cena_o(rom_cena), .rom_qa_i(rom_qa),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_class_o(res_class), .res_score_o(res_score)
    );

    always #5 clk = ~clk;

    logic signed [W_BIAS-1:0] bias_tab [N_BATCH][N_PER];
    logic signed [W_ACC-1:0]  acc_tab  [N_BATCH][N_PER];
    logic signed [W_ACC-1:0]  maxv;
    logic signed [W_ACC-1:0]  minv;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int rom_n    = 0;
    int rom_log [16];
    int acc_n    = 0;
    int acc_t    [16];

    function automatic logic [N_PER*W_ACC-1:0] pack_acc(input int b);
        logic [N_PER*W_ACC-1:0] v;
        v = '0;
        for (int k = 0; k < N_PER; k++) v[(N_PER-k)*W_ACC-1 -: W_ACC] = acc_tab[b][k];
        return v;
    endfunction

    function automatic logic [N_PER*W_BIAS-1:0] pack_bias(input int b);
        logic [N_PER*W_BIAS-1:0] v;
        v = '0;
        for (int k = 0; k < N_PER; k++) v[(N_PER-k)*W_BIAS-1 -: W_BIAS] = bias_tab[b][k];
        return v;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rom_cena) begin
            if (int'(rom_aa) < N_BATCH) rom_qa <= pack_bias(int'(rom_aa));
            if (rom_n < 16) rom_log[rom_n] = int'(rom_aa);
            rom_n++;
        end
        if (!rst && acc_valid && acc_ready) begin
            if (acc_n < 16) acc_t[acc_n] = cyc;
            acc_n++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        acc_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_acc_ready", 64'(acc_ready), 64'd0);
        chk("rst_cena", 64'(rom_cena), 64'd1);
        chk("rst_aa", 64'(rom_aa), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_class", 64'(res_class), 64'd0);
        chk("rst_score", 64'(res_score), 64'd0);
        rst = 1'b0;
    endtask

    task automatic drive_batch(input int b);
        int n;
        n = 0;
        while (!acc_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 64'(acc_ready), 64'd1);
        acc_data  = pack_acc(b);
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int exp_cls, input logic signed [W_ACC-1:0] exp_sc);
        int n;
        for (int b = 0; b < N_BATCH; b++) drive_batch(b);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_class"}, 64'(res_class), 64'(exp_cls));
        chk({tag, "_score"}, 64'(res_score), 64'(unsigned'(exp_sc)));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_release"}, {62'd0, res_valid, acc_ready}, 64'b01);
    endtask

    initial begin
        logic ok;
        int c0, n0;
        maxv = {1'b0, {(W_ACC-1){1'b1}}};
        minv = {1'b1, {(W_ACC-1){1'b0}}};

        do_reset();

        // Ramp biases, zero accumulators: last class wins.
        for (int b = 0; b < N_BATCH; b++)
            for (int k = 0; k < N_PER; k++) begin
                bias_tab[b][k] = W_BIAS'(1000*b + k);
                acc_tab[b][k]  = '0;
            end
        rom_n = 0;
        run_and_check("ramp", 24, 40'sd4004);
        chk("ramp_rom_reads", 64'(rom_n), 64'd5);
        for (int i = 0; i < 5; i++) chk("ramp_rom_addr", 64'(rom_log[i]), 64'(i));

        // Tie: lowest class index keeps the win.
        for (int b = 0; b < N_BATCH; b++)
            for (int k = 0; k < N_PER; k++) begin
                bias_tab[b][k] = '0;
                acc_tab[b][k]  = -40'sd7;
            end
        acc_tab[1][2] = 40'sd500;
        acc_tab[3][0] = 40'sd500;
        run_and_check("tie", 7, 40'sd500);

        // Positive saturation wins; negative saturation is clamped, not wrapped.
        for (int b = 0; b < N_BATCH; b++)
            for (int k = 0; k < N_PER; k++) begin
                bias_tab[b][k] = '0;
                acc_tab[b][k]  = '0;
            end
        acc_tab[2][1] = maxv;  bias_tab[2][1] = 34'sd1;
        acc_tab[0][0] = minv;  bias_tab[0][0] = -34'sd1;
        run_and_check("sat_pos", 11, maxv);
        for (int b = 0; b < N_BATCH; b++)
            for (int k = 0; k < N_PER; k++) begin
                bias_tab[b][k] = -34'sd1;
                acc_tab[b][k]  = minv;
            end
        run_and_check("sat_neg", 0, minv);

        // All negative scores; class 17 is the least negative.
        for (int b = 0; b < N_BATCH; b++)
            for (int k = 0; k < N_PER; k++) begin
                bias_tab[b][k] = W_BIAS'(-(10*b + k) - 5);
                acc_tab[b][k]  = -40'sd100000;
            end
        bias_tab[3][2] = -34'sd2;
        run_and_check("neg", 17, -40'sd100002);

        // Continuous valid: one accept every 8 cycles, exactly five batches.
        for (int b = 0; b < N_BATCH; b++)
            for (int k = 0; k < N_PER; k++) begin
                bias_tab[b][k] = W_BIAS'(1000*b + k);
                acc_tab[b][k]  = '0;
            end
        acc_n = 0;
        acc_data = pack_acc(0);
        acc_valid = 1'b1;
        repeat (45) @(negedge clk);
        chk("hs_valid", 64'(res_valid), 64'd1);
        chk("hs_accepts", 64'(acc_n), 64'd5);
        chk("hs_period", 64'(acc_t[1] - acc_t[0]), 64'd8);
        chk("hs_span", 64'(acc_t[4] - acc_t[0]), 64'd32);
        ok = 1'b1;
        c0 = int'(res_class);
        n0 = acc_n;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!res_valid || acc_ready || int'(res_class) != c0 || res_score != 40'd4004) ok = 1'b0;
        end
        chk("hs_hold_stable", 64'(ok), 64'd1);
        chk("hs_hold_noaccept", 64'(acc_n - n0), 64'd0);
        chk("hs_class", 64'(res_class), 64'd24);
        acc_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_release", {62'd0, res_valid, acc_ready}, 64'b01);

        // Reset during batch 2 compare, then a clean run from batch 0.
        for (int b = 0; b < N_BATCH; b++)
            for (int k = 0; k < N_PER; k++) begin
                bias_tab[b][k] = '0;
                acc_tab[b][k]  = -40'sd7;
            end
        acc_tab[1][2] = 40'sd500;
        acc_tab[3][0] = 40'sd500;
        for (int b = 0; b < 3; b++) drive_batch(b);
        repeat (3) @(negedge clk);
        do_reset();
        rom_n = 0;
        run_and_check("post_rst", 7, 40'sd500);
        chk("post_rst_first_aa", 64'(rom_log[0]), 64'd0);
        chk("post_rst_reads", 64'(rom_n), 64'd5);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/fc3_bias_argmax.md
Name: fc3_bias_argmax

Overview:
- Final FC3 output stage. Consumes FC3 accumulator results one batch at a time.
- For each batch it fetches the matching bias vector from the FC3 bias ROM and adds it lane-wise, with saturation.
- Tracks the running maximum across all classes, then presents the winning class index and its score to the result sink.
- Drives the FC3 bias ROM address and chip-enable directly.

Parameters:
- N_BATCH, 5, number of FC3 output batches per inference.
- N_PER, 5, lanes (classes) per batch.
- W_BIAS, 34, signed bias width per lane, as delivered by the ROM.
- W_ACC, 40, signed accumulator and score width per lane.
- W_AA, 3, ROM address width; must satisfy 2^W_AA >= N_BATCH.
- W_CLS, 5, class index width, equal to clog2(N_BATCH*N_PER).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- acc_valid_i, in, 1: accumulator batch valid.
- acc_ready_o, out, 1: block can accept a batch.
- acc_data_i, in, N_PER*W_ACC: signed lanes; lane k at bits [(N_PER-k)*W_ACC-1 -: W_ACC] (lane 0 at MSBs).
- rom_aa_o, out, W_AA: bias ROM address (batch number).
- rom_cena_o, out, 1: ROM enable, active-low.
- rom_qa_i, in, N_PER*W_BIAS: ROM data, same lane packing; valid the cycle after rom_cena_o=0.
- res_valid_o, out, 1: result valid.
- res_ready_i, in, 1: sink accepts result.
- res_class_o, out, W_CLS: argmax class index.
- res_score_o, out, W_ACC: biased score of that class.

Behaviour:
- Reset values:
  - acc_ready_o=0, then 1 from the first cycle in IDLE.
  - rom_cena_o=1, rom_aa_o=0, res_valid_o=0, res_class_o=0, res_score_o=0.
  - Batch counter=0, lane counter=0, max_valid=0, state=IDLE.
  - Reset takes priority over every event. Asserting it mid-operation discards partial results; the next batch accepted is treated as batch 0.
- FSM:
  - IDLE: acc_ready_o=1. On acc_valid_i & acc_ready_o, latch acc_data_i into lane registers, go to ROM.
  - ROM: rom_cena_o=0, rom_aa_o=batch counter, go to ADD. This is the only state in which rom_cena_o is 0.
  - ADD: each lane becomes sat(sext(acc_lane)+sext(rom_lane)). The sum is computed at W_ACC+1 bits and clamped to [-2^(W_ACC-1), 2^(W_ACC-1)-1]. Result is written back to the lane registers. Lane counter=0. Go to CMP.
  - CMP: one lane per cycle. If max_valid=0 or lane > max (strict signed), then max<=lane, max_idx<=batch*N_PER+lane_cnt, max_valid<=1.
    - At lane_cnt=N_PER-1: if batch=N_BATCH-1, go to DONE; otherwise batch++ and go to IDLE.
  - DONE: res_valid_o=1; res_class_o and res_score_o hold stable.
    - On res_ready_i: res_valid_o<=0, batch<=0, max_valid<=0, go to IDLE.
- Ties: strict greater-than, so the lowest class index wins.
- acc_ready_o=0 in every state except IDLE. acc_valid_i outside IDLE is ignored; the upstream stage must hold its data.
- Per-batch timing: accept at cycle t, ROM at t+1, ADD at t+2, CMP at t+3..t+2+N_PER, IDLE at t+3+N_PER.
- Result timing: res_valid_o rises N_PER+3 cycles after the last batch is accepted.
- res_valid_o persists indefinitely while res_ready_i=0.

Test Plan:
- ROM model: batch b lane k bias = 1000*b+k. Accumulators all 0 -> res_class_o=24, res_score_o=4004; ROM read exactly 5 times, with rom_aa_o = 0,1,2,3,4 in order.
- Tie case: biases all 0; accumulators batch1 lane2=500 and batch3 lane0=500, all others -7 -> res_class_o=7, res_score_o=500.
- Saturation: acc=2^39-1, bias=+1 -> score 2^39-1. acc=-2^39, bias=-1 -> -2^39. A class that saturates to max must win argmax.
- Handshake:
  - Hold acc_valid_i high continuously -> acc_ready_o pulses for 1 cycle every 8 cycles, and exactly 5 batches are accepted.
  - Hold res_ready_i low for 10 cycles -> result stays stable and acc_ready_o stays 0.
  - Then assert res_ready_i -> IDLE next cycle.
- Reset mid-run: assert rst during CMP of batch 2 -> all outputs return to reset values. A fresh 5-batch run then produces the correct result, and the first ROM access uses rom_aa_o=0.
- All-negative scores (acc=-100000, biases negative) -> max is taken correctly from the signed values; max_valid seeding uses class 0 as the initial candidate.
